kalman_track_sched: RTL

- Time-shares one Kalman filter core (the predict → gain → update sequencer) among N_TRACKS independent tracks.
- Performs round-robin arbitration over tracks with pending measurements.
- Sequences the per-track state RAM read, the core start, completion wait, write-back and requester acknowledge.
- Sits between the track front-ends and the core. Core input/output muxing and the state RAM are external and addressed by this block's indices.

---
 rtl/kalman_pkg.sv | 25 ++
 rtl/kalman_track_sched_if.sv | 30 +++
 rtl/kalman_rr_pick.sv | 32 +++
 rtl/kalman_track_sched.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/kalman_pkg.sv
// rtl/kalman_pkg.sv - shared types and constants for the Kalman track scheduler
// Purpose : scheduler state encoding plus the fixed-point format and default
//           filter dimensions used by the surrounding Kalman datapath.
// Ports   : none (package).
package kalman_pkg;

   typedef enum logic [2:0] {
      ST_ARB   = 3'd0,
      ST_LOAD  = 3'd1,
      ST_START = 3'd2,
      ST_WAIT  = 3'd3,
      ST_WB    = 3'd4,
      ST_ACK   = 3'd5,
      ST_HALT  = 3'd6
   } sched_state_e;

   // Q20.12 fixed-point words carried by the filter core.
   localparam int FRAC_BITS = 12;
   localparam int WORD_W    = 32;

   // Default state-vector and measurement-vector sizes.
   localparam int STATE_DIM = 6;
   localparam int MEAS_DIM  = 4;

endpackage

// File: rtl/kalman_track_sched_if.sv
// rtl/kalman_track_sched_if.sv - requester, state-RAM and core handshake bundle
// Purpose : groups the per-track request/ack lines, the state-RAM read and
//           write-back strobes and the core start/done pulses.
// Modports: master - the scheduler (drives ack, RAM strobes, core_start)
//           slave  - front-ends, RAM and core side (drive req, track_en, core_done)
interface kalman_track_sched_if #(
   parameter int N_TRACKS = 4,
   parameter int IDX_W    = $clog2(N_TRACKS)
);
   logic [N_TRACKS-1:0] req;
   logic [N_TRACKS-1:0] track_en;
   logic [N_TRACKS-1:0] ack;
   logic                ack_err;
   logic                rd_en;
   logic [IDX_W-1:0]    rd_idx;
   logic                core_start;
   logic                core_done;
   logic                wb_en;
   logic [IDX_W-1:0]    wb_idx;

   modport master (
      input  req, track_en, core_done,
      output ack, ack_err, rd_en, rd_idx, core_start, wb_en, wb_idx
   );

   modport slave (
      output req, track_en, core_done,
      input  ack, ack_err, rd_en, rd_idx, core_start, wb_en, wb_idx
   );
endinterface

// File: rtl/kalman_rr_pick.sv
// rtl/kalman_rr_pick.sv - combinational round-robin picker
// Purpose : finds the first set bit of eligible searching last+1, last+2, ...
//           modulo N_TRACKS, so the last-served track has lowest priority.
// Ports   : eligible in  N_TRACKS  candidate tracks
//           last     in  IDX_W     most recently served track
//           found    out 1         some track is eligible
//           idx      out IDX_W     chosen track (0 when none found)
module kalman_rr_pick #(
   parameter int N_TRACKS = 4,
   parameter int IDX_W    = $clog2(N_TRACKS)
) (
   input  logic [N_TRACKS-1:0] eligible,
   input  logic [IDX_W-1:0]    last,
   output logic                found,
   output logic [IDX_W-1:0]    idx
);

   always_comb begin
      int j;
      j     = 0;
      found = 1'b0;
      idx   = '0;
      for (int k = 1; k <= N_TRACKS; k++) begin
         j = (int'(last) + k) % N_TRACKS;
         if (!found && eligible[j]) begin
            found = 1'b1;
            idx   = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/kalman_track_sched.sv
// rtl/kalman_track_sched.sv - time-shares one Kalman core among N_TRACKS tracks
// Purpose : round-robin grants a pending track, strobes its state-RAM read,
//           starts the core, waits for done (with a hang timeout), strobes the
//           write-back and acknowledges the requester.
// Ports   : clk, rst        clock, asynchronous active-high reset
//           bus (master)    req/track_en/ack/ack_err, rd_en/rd_idx,
//                           core_start/core_done, wb_en/wb_idx
//           busy            high whenever the scheduler is not arbitrating
//           timeout_err     sticky core-hang flag
//           clr_err         clears timeout_err and releases HALT
module kalman_track_sched
   import kalman_pkg::*;
#(
   parameter int N_TRACKS = 4,
   parameter int IDX_W    = $clog2(N_TRACKS),
   parameter int RD_LAT   = 1,
   parameter int TIMEOUT  = 4096,
   parameter int CNT_W    = $clog2(TIMEOUT + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   kalman_track_sched_if.master bus,
   output logic                 busy,
   output logic                 timeout_err,
   input  logic                 clr_err
);

   sched_state_e        state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [IDX_W-1:0]    last_q, last_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                rd_en_q, rd_en_d;
   logic                core_start_q, core_start_d;
   logic                wb_en_q, wb_en_d;
   logic [N_TRACKS-1:0] ack_q, ack_d;
   logic                ack_err_q, ack_err_d;
   logic                busy_q, busy_d;
   logic                timeout_err_q, timeout_err_d;

   logic [N_TRACKS-1:0] eligible;
   logic                pick_found;
   logic [IDX_W-1:0]    pick_idx;
   logic [N_TRACKS-1:0] idx_onehot;

   assign eligible   = bus.req & bus.track_en;
   assign idx_onehot = N_TRACKS'(1) << idx_q;

   kalman_rr_pick #(
      .N_TRACKS (N_TRACKS),
      .IDX_W    (IDX_W)
   ) u_pick (
      .eligible (eligible),
      .last     (last_q),
      .found    (pick_found),
      .idx      (pick_idx)
   );

   // Every output is a flop, so each branch computes the value the outputs
   // must show while the machine sits in the state it is entering.
   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      last_d        = last_q;
      cnt_d         = cnt_q;
      rd_en_d       = 1'b0;
      core_start_d  = 1'b0;
      wb_en_d       = 1'b0;
      ack_d         = '0;
      ack_err_d     = 1'b0;
      timeout_err_d = timeout_err_q;

      if (clr_err) begin
         timeout_err_d = 1'b0;
      end

      unique case (state_q)
         ST_ARB: begin
            if (pick_found) begin
               idx_d   = pick_idx;
               rd_en_d = 1'b1;
               cnt_d   = CNT_W'(RD_LAT);
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            // cnt enters at RD_LAT, so LOAD lasts exactly RD_LAT cycles.
            if (cnt_q == CNT_W'(1)) begin
               core_start_d = 1'b1;
               state_d      = ST_START;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_START: begin
            cnt_d   = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // A done arriving on the terminal count still completes normally.
            if (bus.core_done) begin
               wb_en_d = 1'b1;
               state_d = ST_WB;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               timeout_err_d = 1'b1;
               ack_d         = idx_onehot;
               ack_err_d     = 1'b1;
               state_d       = ST_HALT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_WB: begin
            ack_d   = idx_onehot;
            state_d = ST_ACK;
         end
         ST_ACK: begin
            last_d  = idx_q;
            state_d = ST_ARB;
         end
         ST_HALT: begin
            // The hung track becomes "last" so it is served last on recovery.
            if (clr_err) begin
               last_d  = idx_q;
               state_d = ST_ARB;
            end
         end
         default: begin
            state_d = ST_ARB;
         end
      endcase

      busy_d = (state_d != ST_ARB);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_ARB;
         idx_q         <= '0;
         last_q        <= IDX_W'(N_TRACKS - 1);
         cnt_q         <= '0;
         rd_en_q       <= 1'b0;
         core_start_q  <= 1'b0;
         wb_en_q       <= 1'b0;
         ack_q         <= '0;
         ack_err_q     <= 1'b0;
         busy_q        <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         last_q        <= last_d;
         cnt_q         <= cnt_d;
         rd_en_q       <= rd_en_d;
         core_start_q  <= core_start_d;
         wb_en_q       <= wb_en_d;
         ack_q         <= ack_d;
         ack_err_q     <= ack_err_d;
         busy_q        <= busy_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign bus.ack        = ack_q;
   assign bus.ack_err    = ack_err_q;
   assign bus.rd_en      = rd_en_q;
   assign bus.rd_idx     = idx_q;
   assign bus.core_start = core_start_q;
   assign bus.wb_en      = wb_en_q;
   assign bus.wb_idx     = idx_q;
   assign busy           = busy_q;
   assign timeout_err    = timeout_err_q;

endmodule
